// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the two-requester logic-unit arbiter: opcodes, FSM states
// and the captured request record.
package alu_share_arbiter_pkg;

    localparam int DW      = 8;
    localparam int CNT_DEF = 16;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    typedef struct packed {
        op_t           op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          id;
    } req_t;

endpackage

// File: rtl/alu_share_arbiter_logic8bit.sv
// Combinational bitwise logic unit: AND via the shared and8bit cell,
// OR/XOR/NOR built locally.
module logic8bit
    import alu_share_arbiter_pkg::*;
(
    input  op_t     op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);
    logic [DW-1:0] y_and, y_or, y_xor, y_nor;

    and8bit u_and (.a(a), .b(b), .y(y_and));

    assign y_or  = a | b;
    assign y_xor = a ^ b;
    assign y_nor = ~(a | b);

    always_comb begin
        y = y_and;
        case (op)
            OP_AND:  y = y_and;
            OP_OR:   y = y_or;
            OP_XOR:  y = y_xor;
            OP_NOR:  y = y_nor;
            default: y = y_and;
        endcase
    end
endmodule

// File: rtl/and8bit.sv
// Existing 8-bit AND cell of the logic datapath.
module and8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);
    assign y = a & b;
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 8-bit logic unit between two requesters, with a
// single registered response port tagged by the winning requester.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DW,
    parameter int CNT_W = CNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic [CNT_W-1:0] ops_done
);
    state_t     state, state_nxt;
    logic       last_grant, grant, take, accept;
    req_t       cap, req_sel;
    logic [WIDTH-1:0] y;

    // Arbitration: a lone requester wins outright; on contention the one that
    // did not win last time goes first.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11)
            grant = ~last_grant;
        else if (req_valid == 2'b10)
            grant = 1'b1;

        req_ready = 2'b00;
        if (state == S_IDLE && (|req_valid) && !reset)
            req_ready[grant] = 1'b1;

        take   = |(req_valid & req_ready);
        accept = (state == S_RESP) && resp_ready;

        req_sel.id = grant;
        req_sel.op = grant ? op_t'(req_op1) : op_t'(req_op0);
        req_sel.a  = grant ? req_a1 : req_a0;
        req_sel.b  = grant ? req_b1 : req_b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (take) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    logic8bit u_logic (
        .op (cap.op),
        .a  (cap.a),
        .b  (cap.b),
        .y  (y)
    );

    // Counter is written every cycle so its value always follows the register
    // contents, including after a preload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            cap        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            ops_done   <= '0;
        end else begin
            if (take) begin
                cap        <= req_sel;
                last_grant <= grant;
            end
            if (state == S_EXEC) begin
                resp_data  <= y;
                resp_id    <= cap.id;
                resp_valid <= 1'b1;
            end
            if (accept)
                resp_valid <= 1'b0;
            ops_done <= ops_done + CNT_W'(accept);
        end
    end
endmodule
